// File: rtl/life_frame_tx.sv
// Snapshots the life grid into a shadow register and streams it out one row per
// valid/ready beat, reporting the frame population and counting dropped snapshots.
module life_frame_tx #(
  parameter int X      = 8,
  parameter int Y      = 8,
  parameter int LOG2X  = 3,
  parameter int LOG2Y  = 3,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [X*Y-1:0]         data,
  input  logic                   snap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [X-1:0]           out_row,
  output logic [LOG2Y-1:0]       out_y,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   busy,
  output logic                   frame_done,
  output logic [LOG2X+LOG2Y:0]   pop_cnt,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int PW = LOG2X + LOG2Y + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, next_state;
  logic [X*Y-1:0]  shadow;
  logic [LOG2Y-1:0] ptr;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   row_pop;
  logic            accept, last;
  logic            load, advance, finish, drop;

  function automatic logic [PW-1:0] popcount(input logic [X-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < X; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  assign out_row = shadow[ptr*X +: X];
  assign out_y   = ptr;
  assign row_pop = popcount(out_row);
  assign last    = (ptr == LOG2Y'(Y - 1));
  assign accept  = (state == SEND) && out_ready;
  assign out_sof = out_valid && (ptr == '0);
  assign out_eof = out_valid && last;
  assign busy    = out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A snap on the final-beat accept restarts immediately; any other snap in SEND is dropped.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (snap) begin
          load       = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (accept && last) begin
          finish = 1'b1;
          if (snap) load = 1'b1;
          else      next_state = IDLE;
        end else begin
          advance = accept;
          drop    = snap;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      ptr        <= '0;
      acc        <= '0;
      pop_cnt    <= '0;
      drop_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= finish;
      if (finish) pop_cnt <= acc + row_pop;
      if (load) begin
        shadow <= data;
        ptr    <= '0;
        acc    <= '0;
      end else if (advance) begin
        ptr <= ptr + 1'b1;
        acc <= acc + row_pop;
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
